car_queue_detector: RTL and testbench

CAR_QUEUE_DETECTOR -- requirements
Module: car_queue_detector

---
 rtl/car_queue_detector.sv | 178 +++++++++++++++++
 tb/tb_car_queue_detector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/car_queue_detector.sv
// ---------------------------------------------------------------------------
// car_queue_debounce
//   One loop-detector channel. The raw loop input is brought into the clock
//   domain through a two-flop synchronizer and then debounced. A level change
//   is accepted only after the synchronized level has disagreed with the
//   filtered level for DEBOUNCE consecutive edges. A one-cycle pulse is
//   registered when the filtered level rises.
//
//   Ports:
//     clock    : rising-edge clock
//     clear    : synchronous active-high reset
//     raw      : asynchronous loop detector level
//     rise_evt : registered one-cycle pulse on a filtered 0->1 transition
// ---------------------------------------------------------------------------
module car_queue_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clock,
  input  logic clear,
  input  logic raw,
  output logic rise_evt
);

  // The counter holds how many earlier edges already saw a disagreement, so
  // the DEBOUNCE-th disagreeing edge is the one that finds DEBOUNCE-1 here.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

  logic       sync_1;
  logic       sync_2;
  logic       filtered;
  logic [3:0] db_count;

  // Synchronizer, debounce qualification and event generation. Clearing
  // empties the whole pipeline, so a loop still occupied when clear drops is
  // seen afresh as a new rising edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      filtered <= 1'b0;
      db_count <= 4'd0;
      rise_evt <= 1'b0;
    end else begin
      sync_1   <= raw;
      sync_2   <= sync_1;
      rise_evt <= 1'b0;
      if (sync_2 == filtered) begin
        db_count <= 4'd0;
      end else if (db_count == DB_LAST) begin
        filtered <= sync_2;
        db_count <= 4'd0;
        rise_evt <= sync_2;
      end else begin
        db_count <= db_count + 4'd1;
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// car_queue_detector
//   Counts vehicles waiting on the country-road approach of a highway/country
//   road intersection. Arrivals are taken from a loop ahead of the stop line,
//   departures from a loop past it. The queue count drives the car-present
//   request X to the light controller. Sticky diagnostic flags record
//   overflow, underflow, departures against a red light and illegal light
//   codes from the controller.
//
//   Parameters:
//     DEBOUNCE : edges a new loop level must persist before acceptance (1..15)
//     MAX_CARS : saturation value of car_count (1..7)
//
//   Ports:
//     clock       : rising-edge clock
//     clear       : synchronous active-high reset
//     arrive_raw  : asynchronous approach loop detector
//     depart_raw  : asynchronous stop-line loop detector
//     cntry       : country-road light (0 RED, 1 YELLOW, 2 GREEN, 3 illegal)
//     X           : car-present request, high while car_count is nonzero
//     car_count   : vehicles currently queued
//     overflow    : sticky, arrival seen while already at MAX_CARS
//     underflow   : sticky, departure seen with an empty queue
//     red_run     : sticky, departure seen while the light was RED
//     illegal_sig : sticky, cntry code 3 observed
// ---------------------------------------------------------------------------
module car_queue_detector #(
  parameter int DEBOUNCE = 3,
  parameter int MAX_CARS = 7
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       arrive_raw,
  input  logic       depart_raw,
  input  logic [1:0] cntry,
  output logic       X,
  output logic [2:0] car_count,
  output logic       overflow,
  output logic       underflow,
  output logic       red_run,
  output logic       illegal_sig
);

  localparam logic [2:0] MAX_COUNT     = 3'(MAX_CARS);
  localparam logic [1:0] CNTRY_RED     = 2'd0;
  localparam logic [1:0] CNTRY_ILLEGAL = 2'd3;

  logic       arrive_evt;
  logic       depart_evt;
  logic [2:0] count_next;
  logic       overflow_hit;
  logic       underflow_hit;

  car_queue_debounce #(.DEBOUNCE(DEBOUNCE)) u_arrive (
    .clock    (clock),
    .clear    (clear),
    .raw      (arrive_raw),
    .rise_evt (arrive_evt)
  );

  car_queue_debounce #(.DEBOUNCE(DEBOUNCE)) u_depart (
    .clock    (clock),
    .clear    (clear),
    .raw      (depart_raw),
    .rise_evt (depart_evt)
  );

  // Next queue count. A simultaneous arrival and departure cancel out and
  // are never treated as an overflow or underflow, whatever the count is.
  always_comb begin
    count_next    = car_count;
    overflow_hit  = 1'b0;
    underflow_hit = 1'b0;
    if (arrive_evt && !depart_evt) begin
      if (car_count == MAX_COUNT) begin
        overflow_hit = 1'b1;
      end else begin
        count_next = car_count + 3'd1;
      end
    end else if (depart_evt && !arrive_evt) begin
      if (car_count == 3'd0) begin
        underflow_hit = 1'b1;
      end else begin
        count_next = car_count - 3'd1;
      end
    end
  end

  // Queue count and sticky diagnostic flags; only clear can drop a flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      car_count   <= 3'd0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      red_run     <= 1'b0;
      illegal_sig <= 1'b0;
    end else begin
      car_count <= count_next;
      if (overflow_hit) begin
        overflow <= 1'b1;
      end
      if (underflow_hit) begin
        underflow <= 1'b1;
      end
      if (depart_evt && (cntry == CNTRY_RED)) begin
        red_run <= 1'b1;
      end
      if (cntry == CNTRY_ILLEGAL) begin
        illegal_sig <= 1'b1;
      end
    end
  end

  // The request comes straight off the count register, so the controller
  // never sees a combinational path from the loop inputs.
  assign X = (car_count != 3'd0);

endmodule

// File: tb/tb_car_queue_detector.sv
// ---------------------------------------------------------------------------
// tb_car_queue_detector
//   Directed bench for car_queue_detector with DEBOUNCE=3, MAX_CARS=7.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_car_queue_detector;

  logic       clock;
  logic       clear;
  logic       arrive_raw;
  logic       depart_raw;
  logic [1:0] cntry;
  logic       X;
  logic [2:0] car_count;
  logic       overflow;
  logic       underflow;
  logic       red_run;
  logic       illegal_sig;

  int check_count;
  int error_count;

  car_queue_detector #(.DEBOUNCE(3), .MAX_CARS(7)) dut (
    .clock       (clock),
    .clear       (clear),
    .arrive_raw  (arrive_raw),
    .depart_raw  (depart_raw),
    .cntry       (cntry),
    .X           (X),
    .car_count   (car_count),
    .overflow    (overflow),
    .underflow   (underflow),
    .red_run     (red_run),
    .illegal_sig (illegal_sig)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_clear();
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
  endtask

  // One qualified arrival: 6 high edges give the count update, 6 low edges
  // let the filtered level fall back before the next one.
  task automatic apply_arrival();
    arrive_raw = 1'b1;
    tick(6);
    arrive_raw = 1'b0;
    tick(6);
  endtask

  task automatic apply_departure();
    depart_raw = 1'b1;
    tick(6);
    depart_raw = 1'b0;
    tick(6);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    clear       = 1'b0;
    arrive_raw  = 1'b0;
    depart_raw  = 1'b0;
    cntry       = 2'd2;
    tick(1);

    // Reset state
    apply_clear();
    check_output("rst_count", 8'(car_count), 8'd0);
    check_output("rst_X", 8'(X), 8'd0);
    check_output("rst_overflow", 8'(overflow), 8'd0);
    check_output("rst_underflow", 8'(underflow), 8'd0);
    check_output("rst_red_run", 8'(red_run), 8'd0);
    check_output("rst_illegal", 8'(illegal_sig), 8'd0);

    // Single held arrival: count changes at the 6th edge after the rise
    arrive_raw = 1'b1;
    tick(5);
    check_output("arr_edge5_count", 8'(car_count), 8'd0);
    check_output("arr_edge5_X", 8'(X), 8'd0);
    tick(1);
    check_output("arr_edge6_count", 8'(car_count), 8'd1);
    check_output("arr_edge6_X", 8'(X), 8'd1);
    tick(4);
    arrive_raw = 1'b0;
    tick(8);
    check_output("arr_hold_count", 8'(car_count), 8'd1);
    check_output("arr_overflow", 8'(overflow), 8'd0);
    check_output("arr_underflow", 8'(underflow), 8'd0);

    // Short glitches are rejected
    apply_clear();
    arrive_raw = 1'b1;
    tick(1);
    arrive_raw = 1'b0;
    tick(8);
    check_output("glitch1_count", 8'(car_count), 8'd0);
    arrive_raw = 1'b1;
    tick(2);
    arrive_raw = 1'b0;
    tick(8);
    check_output("glitch2_count", 8'(car_count), 8'd0);
    check_output("glitch2_X", 8'(X), 8'd0);

    // Saturation at MAX_CARS with overflow on the eighth arrival
    apply_clear();
    for (int i = 1; i <= 8; i++) begin
      apply_arrival();
      check_output("sat_count", 8'(car_count), (i > 7) ? 8'd7 : 8'(i));
      check_output("sat_overflow", 8'(overflow), (i == 8) ? 8'd1 : 8'd0);
    end
    check_output("sat_X", 8'(X), 8'd1);

    // Departures on GREEN down to empty, then underflow
    apply_clear();
    apply_arrival();
    apply_arrival();
    check_output("dep_start", 8'(car_count), 8'd2);
    apply_departure();
    check_output("dep1_count", 8'(car_count), 8'd1);
    check_output("dep1_X", 8'(X), 8'd1);
    apply_departure();
    check_output("dep2_count", 8'(car_count), 8'd0);
    check_output("dep2_X", 8'(X), 8'd0);
    check_output("dep2_underflow", 8'(underflow), 8'd0);
    apply_departure();
    check_output("dep3_count", 8'(car_count), 8'd0);
    check_output("dep3_underflow", 8'(underflow), 8'd1);
    check_output("dep3_red_run", 8'(red_run), 8'd0);

    // Departure on RED
    apply_clear();
    apply_arrival();
    cntry = 2'd0;
    apply_departure();
    check_output("red_count", 8'(car_count), 8'd0);
    check_output("red_run", 8'(red_run), 8'd1);
    check_output("red_underflow", 8'(underflow), 8'd0);

    // Simultaneous arrive and depart at count 3
    cntry = 2'd2;
    apply_clear();
    apply_arrival();
    apply_arrival();
    apply_arrival();
    arrive_raw = 1'b1;
    depart_raw = 1'b1;
    tick(6);
    arrive_raw = 1'b0;
    depart_raw = 1'b0;
    tick(6);
    check_output("both_count", 8'(car_count), 8'd3);
    check_output("both_overflow", 8'(overflow), 8'd0);
    check_output("both_underflow", 8'(underflow), 8'd0);
    check_output("both_red_run", 8'(red_run), 8'd0);

    // Illegal light code is sticky until clear
    cntry = 2'd3;
    tick(1);
    cntry = 2'd2;
    tick(2);
    check_output("illegal_set", 8'(illegal_sig), 8'd1);
    apply_clear();
    check_output("illegal_cleared", 8'(illegal_sig), 8'd0);

    // Clear during debounce restarts qualification from zero
    arrive_raw = 1'b1;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_output("clr_mid_count", 8'(car_count), 8'd0);
    tick(5);
    check_output("clr_edge5_count", 8'(car_count), 8'd0);
    tick(1);
    check_output("clr_edge6_count", 8'(car_count), 8'd1);
    arrive_raw = 1'b0;
    tick(6);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
